// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for a single-port 128x32 data memory (IDLE -> ACCESS -> DONE).
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter #(
   parameter int DEPTH      = 128,
   parameter int ADDR_SHIFT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_ack,
   output logic        p0_err,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_ack,
   output logic        p1_err,
   output logic [31:0] p1_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        any_req;
   logic        grant;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] widx_in;
   logic        err_in;

   logic        sel_q;
   logic        we_q;
   logic [31:0] widx_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] rdata0_q;
   logic [31:0] rdata1_q;
   logic [31:0] rd_cap;

`ifdef DMEM_ARB_RR_EN
   logic        rr_last;
`endif

   assign any_req = p0_req | p1_req;

   // grant = 1 selects port 1; only meaningful while IDLE with a request pending
   always_comb begin
`ifdef DMEM_ARB_RR_EN
      if (p0_req && p1_req) grant = ~rr_last;
      else                  grant = ~p0_req;
`else
      grant = ~p0_req;
`endif
   end

   assign req_we    = grant ? p1_we    : p0_we;
   assign req_addr  = grant ? p1_addr  : p0_addr;
   assign req_wdata = grant ? p1_wdata : p0_wdata;
   assign widx_in   = req_addr >> ADDR_SHIFT;
   assign err_in    = (widx_in >= DEPTH_W);

   // Reads of an out-of-range address and all writes return zero
   assign rd_cap = (!we_q && !err_q) ? mem_rdata : 32'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rdata0_q <= 32'd0;
         rdata1_q <= 32'd0;
`ifdef DMEM_ARB_RR_EN
         rr_last  <= 1'b1;
`endif
      end else begin
         state <= state_nxt;
         if (state == ACCESS) begin
            if (sel_q) rdata1_q <= rd_cap;
            else       rdata0_q <= rd_cap;
         end
`ifdef DMEM_ARB_RR_EN
         if (state == IDLE && any_req) rr_last <= grant;
`endif
      end
   end

   // Transaction latch; its contents only reach the outputs in ACCESS/DONE, so no reset
   always_ff @(posedge clk) begin
      if (state == IDLE && any_req) begin
         sel_q   <= grant;
         we_q    <= req_we;
         widx_q  <= widx_in;
         wdata_q <= req_wdata;
         err_q   <= err_in;
      end
   end

   always_comb begin
      state_nxt = state;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      p0_ack    = 1'b0;
      p0_err    = 1'b0;
      p0_rdata  = rdata0_q;
      p1_ack    = 1'b0;
      p1_err    = 1'b0;
      p1_rdata  = rdata1_q;
      case (state)
         IDLE: begin
            if (any_req) state_nxt = ACCESS;
         end
         ACCESS: begin
            mem_addr  = widx_q;
            mem_wdata = wdata_q;
            mem_write = we_q & ~err_q;
            mem_read  = ~we_q & ~err_q;
            state_nxt = DONE;
         end
         DONE: begin
            if (sel_q) begin
               p1_ack   = 1'b1;
               p1_err   = err_q;
               p0_rdata = 32'd0;
            end else begin
               p0_ack   = 1'b1;
               p0_err   = err_q;
               p1_rdata = 32'd0;
            end
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: two requesters, a behavioural memory and a
// transaction-level reference model that predicts every output on every cycle.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_ack, p0_err, p1_ack, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_write, mem_read, busy;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
   );

   // Memory seen by the DUT
   logic [31:0] mem [0:127];
   assign mem_rdata = mem[mem_addr[6:0]];
   always @(posedge clk) if (mem_write) mem[mem_addr[6:0]] <= mem_wdata;

   int checks = 0;
   int errors = 0;
   int cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 7))
         0:       return 32'h200 | 32'($urandom_range(0, 3));
         1:       return $urandom();
         2:       return 32'h1FC;
         default: return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      endcase
   endfunction

   // Requesters
   logic        act  [2];
   logic        we_r [2];
   logic [31:0] addr_r [2];
   logic [31:0] wd_r   [2];

   // Reference model: one transaction occupies three cycles starting at the IDLE sample
   logic [31:0] shadow [0:127];
   logic [31:0] hold [2];
   int          acc_c, done_c, free_at;
   logic        win;
`ifdef DMEM_ARB_RR_EN
   logic        last;
`endif
   logic        m_we, m_err;
   logic [31:0] m_widx, m_wdata, rd_val;
   logic        rst_now;

   task automatic model_reset();
      acc_c   = -1;
      done_c  = -1;
      free_at = cyc + 1;
      hold[0] = 32'd0;
      hold[1] = 32'd0;
`ifdef DMEM_ARB_RR_EN
      last    = 1'b1;
`endif
      act[0]  = 1'b0;
      act[1]  = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem[i]    = $urandom();
         shadow[i] = mem[i];
      end
      win = 1'b0; m_we = 1'b0; m_err = 1'b0; m_widx = 0; m_wdata = 0;
      cyc = -1;
      model_reset();
      for (int p = 0; p < 2; p++) begin
         we_r[p] = 1'b0; addr_r[p] = 0; wd_r[p] = 0;
      end
      rst = 1'b1;
      p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      free_at = 0;

      for (cyc = 0; cyc < 3000; cyc++) begin
         for (int p = 0; p < 2; p++) begin
            if (!act[p] && $urandom_range(0, 2) != 0) begin
               act[p]    = 1'b1;
               we_r[p]   = $urandom_range(0, 1) == 1;
               addr_r[p] = rand_addr();
               wd_r[p]   = $urandom();
            end
         end
         rst_now = (cyc > 5) && (((cyc == acc_c) && m_we && ($urandom_range(0, 5) == 0))
                                 || ($urandom_range(0, 199) == 0));
         rst      = rst_now;
         p0_req   = act[0]; p0_we = we_r[0]; p0_addr = addr_r[0]; p0_wdata = wd_r[0];
         p1_req   = act[1]; p1_we = we_r[1]; p1_addr = addr_r[1]; p1_wdata = wd_r[1];

         @(negedge clk);
         check("busy",      busy,      (cyc == acc_c) || (cyc == done_c));
         check("mem_addr",  mem_addr,  (cyc == acc_c) ? m_widx : 32'd0);
         check("mem_wdata", mem_wdata, (cyc == acc_c) ? m_wdata : 32'd0);
         check("mem_write", mem_write, (cyc == acc_c) && m_we && !m_err);
         check("mem_read",  mem_read,  (cyc == acc_c) && !m_we && !m_err);
         check("p0_ack",    p0_ack,    (cyc == done_c) && !win);
         check("p0_err",    p0_err,    (cyc == done_c) && !win && m_err);
         check("p0_rdata",  p0_rdata,  ((cyc == done_c) && win) ? 32'd0 : hold[0]);
         check("p1_ack",    p1_ack,    (cyc == done_c) && win);
         check("p1_err",    p1_err,    (cyc == done_c) && win && m_err);
         check("p1_rdata",  p1_rdata,  ((cyc == done_c) && !win) ? 32'd0 : hold[1]);

         // Effects of the closing edge of this cycle
         rd_val = 32'd0;
         if (cyc == acc_c) begin
            if (!m_we && !m_err) rd_val = shadow[m_widx[6:0]];
            if (m_we && !m_err)  shadow[m_widx[6:0]] = m_wdata;
         end
         if (rst_now) begin
            model_reset();
         end else begin
            if (cyc == acc_c)  hold[win] = rd_val;
            if (cyc == done_c) act[win] = 1'b0;
            if (cyc >= free_at && (act[0] || act[1])) begin
               if (act[0] && act[1]) begin
`ifdef DMEM_ARB_RR_EN
                  win = !last;
`else
                  win = 1'b0;
`endif
               end else begin
                  win = act[1];
               end
`ifdef DMEM_ARB_RR_EN
               last = win;
`endif
               m_we    = we_r[win];
               m_widx  = addr_r[win] / 4;
               m_err   = (m_widx >= 128);
               m_wdata = wd_r[win];
               acc_c   = cyc + 1;
               done_c  = cyc + 2;
               free_at = cyc + 3;
            end
         end
         @(posedge clk);
         #1;
      end

      for (int i = 0; i < 128; i++) check("mem_final", mem[i], shadow[i]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
